// File: rtl/lsu_axi_master_pkg.sv
// Shared definitions for the LSU AXI4 initiator: FSM states, AXI response
// codes, burst encoding and the response-error check.
package lsu_axi_master_pkg;

  typedef enum logic [2:0] {
    LSU_AXI_IDLE  = 3'd0,
    LSU_AXI_WRITE = 3'd1,
    LSU_AXI_WRESP = 3'd2,
    LSU_AXI_RADDR = 3'd3,
    LSU_AXI_RDATA = 3'd4
  } lsu_axi_state_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int unsigned AXI_ID_W  = 4;

  // Anything but OKAY, or a response routed back under a foreign ID, is an error.
  function automatic logic axi_resp_bad(input logic [1:0]          resp,
                                        input logic [AXI_ID_W-1:0] id,
                                        input logic [AXI_ID_W-1:0] exp_id);
    return (resp != AXI_RESP_OKAY) || (id != exp_id);
  endfunction

endpackage

// File: rtl/lsu_axi_master.sv
// Single-outstanding AXI4 initiator: converts one core load/store request into
// one single-beat AXI4 transaction and returns a one-cycle response pulse.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] AXI_ID = 4'd0,
  parameter int unsigned         ADDR_W = 32,
  parameter int unsigned         DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // core request / response
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  // write address
  output logic                awvalid,
  input  logic                awready,
  output logic [AXI_ID_W-1:0] awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  // write data
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  // write response
  input  logic                bvalid,
  output logic                bready,
  input  logic [AXI_ID_W-1:0] bid,
  input  logic [1:0]          bresp,
  // read address
  output logic                arvalid,
  input  logic                arready,
  output logic [AXI_ID_W-1:0] arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  // read data
  input  logic                rvalid,
  output logic                rready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [1:0]          rresp,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rlast
);

  localparam int unsigned STRB_W = DATA_W / 8;

  lsu_axi_state_e      state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wmask_q;

  // A channel counts as done once its valid has dropped or it handshakes now.
  logic aw_fin_c;
  logic w_fin_c;
  assign aw_fin_c = !awvalid_q || awready;
  assign w_fin_c  = !wvalid_q  || wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LSU_AXI_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        LSU_AXI_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            wen_q       <= req_wen;
            addr_q      <= req_addr;
            size_q      <= req_size;
            wdata_q     <= req_wdata;
            wmask_q     <= req_wmask;
            if (req_wen) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= LSU_AXI_WRITE;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= LSU_AXI_RADDR;
            end
          end
        end
        LSU_AXI_WRITE: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_fin_c && w_fin_c) begin
            bready_q <= 1'b1;
            state_q  <= LSU_AXI_WRESP;
          end
        end
        LSU_AXI_WRESP: begin
          if (bvalid) begin
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= axi_resp_bad(bresp, bid, AXI_ID);
            req_ready_q  <= 1'b1;
            state_q      <= LSU_AXI_IDLE;
          end
        end
        LSU_AXI_RADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= LSU_AXI_RDATA;
          end
        end
        LSU_AXI_RDATA: begin
          if (rvalid) begin
            rready_q     <= 1'b0;
            if (!wen_q) resp_rdata_q <= rdata;
            resp_valid_q <= 1'b1;
            resp_err_q   <= axi_resp_bad(rresp, rid, AXI_ID) || !rlast;
            req_ready_q  <= 1'b1;
            state_q      <= LSU_AXI_IDLE;
          end
        end
        default: state_q <= LSU_AXI_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign awvalid = awvalid_q;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;

  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wmask_q;
  assign wlast   = 1'b1;

  assign bready  = bready_q;

  assign arvalid = arvalid_q;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;

  assign rready  = rready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: inputs driven and outputs sampled on the
// falling edge, expected values hand-derived from the cycle-level behaviour.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic [63:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata),
    .rlast(rlast)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Store against a responder with AW/W always ready; ends on the response cycle.
  task automatic store_fast(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m,
                            input logic [1:0] br, input logic [3:0] bi,
                            input logic exp_err, input logic [63:0] exp_rdata);
    awready = 1'b1; wready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = a; req_size = 3'd3;
    req_wdata = d; req_wmask = m;
    step();
    req_valid = 1'b0;
    chk("st_awvalid", 64'(awvalid), 64'd1);
    chk("st_wvalid", 64'(wvalid), 64'd1);
    chk("st_awaddr", 64'(awaddr), 64'(a));
    chk("st_wdata", wdata, d);
    chk("st_wstrb", 64'(wstrb), 64'(m));
    chk("st_wlast", 64'(wlast), 64'd1);
    chk("st_busy", 64'(req_ready), 64'd0);
    bvalid = 1'b1; bresp = br; bid = bi;
    step();
    chk("st_bready", 64'(bready), 64'd1);
    chk("st_aw_drop", 64'(awvalid), 64'd0);
    chk("st_no_resp_yet", 64'(resp_valid), 64'd0);
    step();
    bvalid = 1'b0;
    chk("st_resp_valid", 64'(resp_valid), 64'd1);
    chk("st_resp_err", 64'(resp_err), 64'(exp_err));
    chk("st_rdata_kept", resp_rdata, exp_rdata);
    chk("st_req_ready", 64'(req_ready), 64'd1);
  endtask

  // Load against a responder with AR always ready; ends on the response cycle.
  task automatic load_fast(input logic [31:0] a, input logic [63:0] rd, input logic [1:0] rr,
                           input logic [3:0] ri, input logic rl, input logic exp_err);
    chk("ld_req_ready", 64'(req_ready), 64'd1);
    arready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = a; req_size = 3'd2;
    step();
    req_valid = 1'b0;
    chk("ld_arvalid", 64'(arvalid), 64'd1);
    chk("ld_araddr", 64'(araddr), 64'(a));
    chk("ld_arsize", 64'(arsize), 64'd2);
    step();
    chk("ld_rready", 64'(rready), 64'd1);
    chk("ld_ar_drop", 64'(arvalid), 64'd0);
    rvalid = 1'b1; rdata = rd; rresp = rr; rid = ri; rlast = rl;
    step();
    rvalid = 1'b0;
    chk("ld_resp_valid", 64'(resp_valid), 64'd1);
    chk("ld_rdata", resp_rdata, rd);
    chk("ld_resp_err", 64'(resp_err), 64'(exp_err));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wmask = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rresp = '0; rdata = '0; rlast = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state and constant outputs
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    chk("const_awlen_arlen", 64'({awlen, arlen}), 64'd0);
    chk("const_bursts", 64'({awburst, arburst}), 64'b0101);
    chk("const_ids", 64'({awid, arid}), 64'd0);

    // Store, always-ready responder
    store_fast(32'h0200_4000, 64'h1234, 8'hFF, 2'b00, 4'd0, 1'b0, 64'd0);
    step();
    chk("st1_pulse_once", 64'(resp_valid), 64'd0);

    // Store with AW delayed: W accepted at once, AW held four cycles
    awready = 1'b0; wready = 1'b1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010;
    req_wdata = 64'hA5A5; req_wmask = 8'h0F;
    step();
    req_valid = 1'b0;
    chk("sk_wvalid_c1", 64'(wvalid), 64'd1);
    for (int c = 1; c <= 4; c++) begin
      chk("sk_awvalid_held", 64'(awvalid), 64'd1);
      chk("sk_awaddr_stable", 64'(awaddr), 64'h8000_0010);
      chk("sk_no_bready", 64'(bready), 64'd0);
      if (c >= 2) chk("sk_wvalid_dropped", 64'(wvalid), 64'd0);
      if (c == 4) awready = 1'b1;
      step();
    end
    chk("sk_aw_done", 64'(awvalid), 64'd0);
    chk("sk_bready", 64'(bready), 64'd1);
    bvalid = 1'b1; bresp = 2'b00; bid = 4'd0;
    step();
    chk("sk_resp_valid", 64'(resp_valid), 64'd1);
    chk("sk_resp_err", 64'(resp_err), 64'd0);
    chk("sk_bready_off", 64'(bready), 64'd0);
    step();
    chk("sk_single_b", 64'(resp_valid), 64'd0);
    bvalid = 1'b0;

    // Load with slow AR and R
    arready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0200_bff8; req_size = 3'd3;
    step();
    req_valid = 1'b0;
    chk("sl_arvalid_c1", 64'(arvalid), 64'd1);
    chk("sl_araddr", 64'(araddr), 64'h0200_bff8);
    step();
    chk("sl_arvalid_c2", 64'(arvalid), 64'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("sl_rready_wait", 64'(rready), 64'd1);
      chk("sl_arvalid_off", 64'(arvalid), 64'd0);
      chk("sl_no_resp", 64'(resp_valid), 64'd0);
      if (c == 3) begin
        rvalid = 1'b1; rdata = 64'hDEAD_BEEF; rresp = 2'b00; rid = 4'd0; rlast = 1'b1;
      end
      step();
    end
    rvalid = 1'b0;
    chk("sl_resp_valid", 64'(resp_valid), 64'd1);
    chk("sl_rdata", resp_rdata, 64'hDEAD_BEEF);
    chk("sl_resp_err", 64'(resp_err), 64'd0);
    step();
    chk("sl_pulse_once", 64'(resp_valid), 64'd0);
    chk("sl_rdata_held", resp_rdata, 64'hDEAD_BEEF);

    // Error paths
    store_fast(32'h1000_0000, 64'h55, 8'h01, 2'b11, 4'd0, 1'b1, 64'hDEAD_BEEF);
    step();
    load_fast(32'h8000_0100, 64'h1111, 2'b00, 4'd5, 1'b1, 1'b1);
    step();
    load_fast(32'h8000_0108, 64'h2222, 2'b00, 4'd0, 1'b0, 1'b1);
    step();
    load_fast(32'h8000_0110, 64'h3333, 2'b00, 4'd0, 1'b1, 1'b0);
    step();

    // Back-to-back: load issued in the store's response cycle
    store_fast(32'h0200_0000, 64'h77, 8'hFF, 2'b00, 4'd0, 1'b0, 64'h3333);
    load_fast(32'h0200_0008, 64'h4444_0000_9999, 2'b00, 4'd0, 1'b1, 1'b0);
    step();

    // Reset while waiting on B
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0200_4008; req_wdata = 64'h1; req_wmask = 8'hFF;
    step();
    req_valid = 1'b0;
    step();
    chk("rw_bready_before", 64'(bready), 64'd1);
    rst = 1'b1;
    #1;
    chk("rw_bready_async", 64'(bready), 64'd0);
    chk("rw_valids_async", 64'({awvalid, wvalid, arvalid, rready}), 64'd0);
    chk("rw_req_ready_async", 64'(req_ready), 64'd1);
    chk("rw_rdata_cleared", resp_rdata, 64'd0);
    step();
    rst = 1'b0;
    bvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rw_no_resp", 64'(resp_valid), 64'd0);
      chk("rw_req_ready", 64'(req_ready), 64'd1);
      chk("rw_bready_off", 64'(bready), 64'd0);
    end
    bvalid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- AXI4 initiator that turns the core's single load/store request into one single-beat AXI4 transaction.
- Drives the AW/W/B and AR/R channels towards the interconnect, which routes to the CLINT, RAM and UART responders.
- Returns one registered response pulse per request, carrying the read data and an error flag.
- Only one transaction is outstanding at a time; no bursts.

Parameters:
- AXI_ID, 4'd0, constant value driven on awid/arid and expected back on bid/rid.
- ADDR_W, 32, address width.
- DATA_W, 64, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  master can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_size  in  3  AXI size encoding (0..3)
- req_wdata  in  DATA_W  store data, already lane-aligned
- req_wmask  in  DATA_W/8  store byte strobes
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_W  load data, valid with resp_valid
- resp_err  out  1  bad bresp/rresp, ID mismatch, or missing rlast
- awvalid/awready out/in 1; awid out 4; awaddr out ADDR_W; awlen out 8; awsize out 3; awburst out 2
- wvalid/wready out/in 1; wdata out DATA_W; wstrb out DATA_W/8; wlast out 1
- bvalid in 1; bready out 1; bid in 4; bresp in 2
- arvalid/arready out/in 1; arid out 4; araddr out ADDR_W; arlen out 8; arsize out 3; arburst out 2
- rvalid in 1; rready out 1; rid in 4; rresp in 2; rdata in DATA_W; rlast in 1

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-transaction):
  - state = IDLE; all valid/ready outputs 0 except req_ready = 1.
  - resp_valid = 0; resp_rdata = 0; resp_err = 0; captured request registers = 0.
  - An in-flight transaction is abandoned; no response is issued.
- Constant outputs: awlen = arlen = 0, awburst = arburst = 2'b01 (INCR), wlast = 1, awid = arid = AXI_ID.
- req_ready = 1 only in IDLE. Handshake when req_valid && req_ready; addr, size, wdata, wmask and wen are registered that edge.
- IDLE:
  - Handshake with wen = 1 -> WRITE.
  - Handshake with wen = 0 -> RADDR.
- WRITE:
  - awvalid = !aw_done; wvalid = !w_done. AW and W are presented together, starting the cycle after the handshake.
  - aw_done sets on awvalid && awready; w_done sets on wvalid && wready. The two may complete in the same cycle or in either order.
  - Once a valid is asserted it stays asserted, with payload stable, until its handshake.
  - When both are done (including the same-cycle case) -> WRESP; both flags clear.
- WRESP:
  - bready = 1.
  - On bvalid: resp_valid = 1 next cycle; resp_err = (bresp != 2'b00) || (bid != AXI_ID); -> IDLE.
- RADDR:
  - arvalid = 1 until arready -> RDATA.
- RDATA:
  - rready = 1.
  - On rvalid: resp_rdata <= rdata; resp_err = (rresp != 2'b00) || (rid != AXI_ID) || !rlast; resp_valid next cycle; -> IDLE.
- Response:
  - resp_valid is high for exactly one cycle, coinciding with the return to IDLE, so req_ready = 1 in the same cycle.
  - resp_rdata holds its value until the next load completes.
  - For stores, resp_rdata is unchanged.
- Minimum latency, ready responders:
  - Store: req handshake at edge 0; AW/W accepted at edge 1; bvalid at edge 2; resp_valid high in cycle 3. That is 3 cycles.
  - Load: also 3 cycles.
- Back-to-back: a new request may be accepted in the same cycle as resp_valid.
- Inputs bvalid/rvalid arriving outside WRESP/RDATA are ignored, since bready/rready are 0 there.

Decomposition:
- Shared package/macro file:
  - State encodings LSU_AXI_IDLE/WRITE/WRESP/RADDR/RDATA.
  - AXI resp codes OKAY/EXOKAY/SLVERR/DECERR.
  - BURST_INCR.
  - These sit alongside the existing CLINT state macros.
- No sub-module. A single FSM plus capture registers is sufficient.

Test Plan:
- Store with always-ready responder: addr 0x0200_4000, wdata 0x1234, wmask 0xFF -> awaddr = 0x0200_4000, wstrb = 0xFF, wlast = 1 in cycle 1; resp_valid in cycle 3 with resp_err = 0.
- Store with skewed channels: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid held 4 cycles with awaddr stable; exactly one B accepted; resp_err = 0.
- Load with a slow responder: araddr 0x0200_bff8, arready after 2 cycles, rvalid after a further 4 cycles with rdata 0xDEAD_BEEF, rlast = 1 -> resp_rdata = 0xDEAD_BEEF, resp_valid pulses once.
- Error paths:
  - bresp = 2'b11 -> resp_err = 1.
  - rid = 4'd5 with AXI_ID = 0 -> resp_err = 1.
  - rvalid with rlast = 0 -> resp_err = 1.
- Back-to-back: a load issued in the resp_valid cycle of a preceding store -> accepted that cycle; arvalid is asserted the next cycle.
- Reset mid-WRESP: assert rst while bready = 1 -> all valids/readies drop immediately; req_ready = 1 after release; no resp_valid pulse.
